button_debouncer: RTL

//   Input-side counterpart to the board LED drivers. It reads one raw

---
 rtl/button_debouncer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button front end: 2-flop synchroniser, debounce FSM, press/release/long pulses, press counter.
// Define BTN_AUTO_REPEAT_EN to make a held button (past the long-press point) repeat oPRESS.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 32,
    parameter int CNT_W           = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iBTN,
    output logic             oLEVEL,
    output logic             oPRESS,
    output logic             oRELEASE,
    output logic             oLONG,
    output logic [CNT_W-1:0] oCOUNT
);

    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_debouncer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_WAIT = 3'd1,
        PRESSED    = 3'd2,
        HOLD       = 3'd3,
        REL_WAIT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, s_q;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             d_done, h_done;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          r_done;
    assign r_done = (rcnt_q == R_LAST);
`endif

    assign d_done = (dcnt_q == D_LAST);
    assign h_done = (hcnt_q == H_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            s_q         <= 1'b0;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= iBTN;
            s_q         <= sync1_q;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_q      <= rcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (s_q) state_d = PRESS_WAIT;
            PRESS_WAIT: if (!s_q) state_d = IDLE;
                        else if (d_done) state_d = PRESSED;
            PRESSED:    if (!s_q) state_d = REL_WAIT;
                        else if (h_done) state_d = HOLD;
            HOLD:       if (!s_q) state_d = REL_WAIT;
            // A short dip while pressed returns to where it left off.
            REL_WAIT:   if (s_q) state_d = long_done_q ? HOLD : PRESSED;
                        else if (d_done) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;
`ifdef BTN_AUTO_REPEAT_EN
        rcnt_d      = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_q) dcnt_d = '0;
            end
            PRESS_WAIT: begin
                if (s_q) begin
                    if (d_done) begin
                        level_d = 1'b1;
                        press_d = 1'b1;
                        count_d = count_q + 1'b1;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!s_q) begin
                    dcnt_d      = '0;
                    long_done_d = 1'b0;
                end else if (h_done) begin
                    long_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    rcnt_d = '0;
`endif
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!s_q) begin
                    dcnt_d      = '0;
                    long_done_d = 1'b1;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (r_done) begin
                    press_d = 1'b1;
                    count_d = count_q + 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
`endif
            end
            REL_WAIT: begin
                if (!s_q) begin
                    if (d_done) begin
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                dcnt_d = '0;
            end
        endcase
    end

    always_comb begin
        oLEVEL   = level_q;
        oPRESS   = press_q;
        oRELEASE = release_q;
        oLONG    = long_q;
        oCOUNT   = count_q;
    end

endmodule
